pc_sequencer: RTL and testbench

- Parametrised instruction-fetch and program-counter sequencer for the single-cycle core. It replaces the ad-hoc PC register and instruction-memory address mux.
- Owns the instruction memory, a host program-load port and the PC update logic.
- Owns the condition-flag register and the branch decision for jz/jnz/jl/jg/jmp.
- Adds run/halt/stall control and a retired-instruction counter.
- Feeds the instruction word to the control unit and register file.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/instr_mem.sv | 25 ++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Bit positions inside the {z,l,g} flag register
  localparam int FLAG_Z = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_G = 0;

  // Taken if any enabled branch condition holds against the given flags
  function automatic logic branchTaken(
    input logic [2:0] flags,
    input logic       isJz,
    input logic       isJnz,
    input logic       isJl,
    input logic       isJg,
    input logic       isJump
  );
    return isJump
         | (isJz  &  flags[FLAG_Z])
         | (isJnz & ~flags[FLAG_Z])
         | (isJl  &  flags[FLAG_L])
         | (isJg  &  flags[FLAG_G]);
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write from the host, asynchronous read for fetch.
module instr_mem #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [2**ADDR_W];

  // Host program load; contents are deliberately never cleared by reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch / program-counter sequencer with run/halt/stall control,
// condition flags, branch resolution and a saturating retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               halt_req,
  input  logic               stall,
  input  logic               flags_write,
  input  logic               z_in,
  input  logic               l_in,
  input  logic               g_in,
  input  logic               is_jz,
  input  logic               is_jnz,
  input  logic               is_jl,
  input  logic               is_jg,
  input  logic               is_jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [1:0]         state,
  output logic [2:0]         flags,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [2:0]         r_flags;
  logic [CNT_W-1:0]   r_retired;

  logic               w_memWe;
  logic               w_taken;
  logic [2:0]         w_newFlags;

  // Host writes are blocked while running and dropped when reset coincides
  assign w_memWe = load_en && (r_state != RUN) && !rst;

  // Branch decision always looks at the registered flags, never same-cycle ALU results
  assign w_taken = branchTaken(r_flags, is_jz, is_jnz, is_jl, is_jg, is_jump);

  assign w_newFlags[FLAG_Z] = z_in;
  assign w_newFlags[FLAG_L] = l_in;
  assign w_newFlags[FLAG_G] = g_in;

  instr_mem #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_memWe),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (instr)
  );

  // Sequencer FSM: halt beats stall, stall beats branch, branch beats increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC_V;
      r_flags   <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_pc    <= RESET_PC_V;
          end
        end
        RUN: begin
          if (halt_req) begin
            r_state <= HALT;
          end else if (!stall) begin
            r_pc <= w_taken ? jump_target : (r_pc + ADDR_W'(1));
            if (r_retired != '1) begin
              r_retired <= r_retired + CNT_W'(1);
            end
            if (flags_write) begin
              r_flags <= w_newFlags;
            end
          end
        end
        HALT: begin
          if (start) begin
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pc          = r_pc;
  assign state       = r_state;
  assign flags       = r_flags;
  assign retired     = r_retired;
  assign instr_valid = (r_state == RUN) && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected fetches, a monitor
// pops them whenever a DUT presents a valid instruction.
module tb_pc_sequencer;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [15:0] retired;
    logic [2:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadEn;
  logic [7:0]  loadAddr;
  logic [15:0] loadData;
  logic        start, haltReq, stall, flagsWrite;
  logic        zIn, lIn, gIn;
  logic        isJz, isJnz, isJl, isJg, isJump;
  logic [7:0]  jumpTarget;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        instrValid;
  logic [1:0]  state;
  logic [2:0]  flags;
  logic [15:0] retired;

  logic        wRst;
  logic        wLoadEn;
  logic [7:0]  wLoadAddr;
  logic [15:0] wLoadData;
  logic        wStart;
  logic [7:0]  wPc;
  logic [15:0] wInstr;
  logic        wInstrValid;
  logic [1:0]  wState;
  logic [2:0]  wFlags;
  logic [1:0]  wRetired;

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];
  exp_t wrapQ[$];
  exp_t mainItem;
  exp_t wrapItem;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0), .CNT_W(16)) uDut (
    .clk(clk), .rst(rst), .load_en(loadEn), .load_addr(loadAddr), .load_data(loadData),
    .start(start), .halt_req(haltReq), .stall(stall), .flags_write(flagsWrite),
    .z_in(zIn), .l_in(lIn), .g_in(gIn),
    .is_jz(isJz), .is_jnz(isJnz), .is_jl(isJl), .is_jg(isJg), .is_jump(isJump),
    .jump_target(jumpTarget), .pc(pc), .instr(instr), .instr_valid(instrValid),
    .state(state), .flags(flags), .retired(retired)
  );

  pc_sequencer #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE), .CNT_W(2)) uWrap (
    .clk(clk), .rst(wRst), .load_en(wLoadEn), .load_addr(wLoadAddr), .load_data(wLoadData),
    .start(wStart), .halt_req(1'b0), .stall(1'b0), .flags_write(1'b0),
    .z_in(1'b0), .l_in(1'b0), .g_in(1'b0),
    .is_jz(1'b0), .is_jnz(1'b0), .is_jl(1'b0), .is_jg(1'b0), .is_jump(1'b0),
    .jump_target(8'h00), .pc(wPc), .instr(wInstr), .instr_valid(wInstrValid),
    .state(wState), .flags(wFlags), .retired(wRetired)
  );

  // Monitor: every valid fetch must match the oldest expected entry
  always @(negedge clk) begin
    if (instrValid) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL mainFetch unexpected: pc=%h instr=%h ret=%0d", pc, instr, retired);
      end else begin
        mainItem = expQ.pop_front();
        if (pc !== mainItem.pc || instr !== mainItem.instr ||
            retired !== mainItem.retired || flags !== mainItem.flags) begin
          bad++;
          $display("[TB] FAIL mainFetch got pc=%h instr=%h ret=%0d flags=%b want pc=%h instr=%h ret=%0d flags=%b",
                   pc, instr, retired, flags, mainItem.pc, mainItem.instr, mainItem.retired, mainItem.flags);
        end
      end
    end
    if (wInstrValid) begin
      total++;
      if (wrapQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL wrapFetch unexpected: pc=%h instr=%h ret=%0d", wPc, wInstr, wRetired);
      end else begin
        wrapItem = wrapQ.pop_front();
        if (wPc !== wrapItem.pc || wInstr !== wrapItem.instr ||
            {14'd0, wRetired} !== wrapItem.retired || wFlags !== wrapItem.flags) begin
          bad++;
          $display("[TB] FAIL wrapFetch got pc=%h instr=%h ret=%0d flags=%b want pc=%h instr=%h ret=%0d flags=%b",
                   wPc, wInstr, wRetired, wFlags, wrapItem.pc, wrapItem.instr, wrapItem.retired, wrapItem.flags);
        end
      end
    end
  end

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic clearInputs;
    loadEn = 0; loadAddr = 0; loadData = 0; start = 0; haltReq = 0; stall = 0;
    flagsWrite = 0; zIn = 0; lIn = 0; gIn = 0;
    isJz = 0; isJnz = 0; isJl = 0; isJg = 0; isJump = 0; jumpTarget = 0;
    wLoadEn = 0; wLoadAddr = 0; wLoadData = 0; wStart = 0;
  endtask

  // Move to the next cycle and drive inputs shortly after the edge
  task automatic applyStimulus;
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic expectFetch(input logic [7:0] ePc, input logic [15:0] eInstr,
                             input logic [15:0] eRet, input logic [2:0] eFlags);
    exp_t e;
    e.pc = ePc; e.instr = eInstr; e.retired = eRet; e.flags = eFlags;
    expQ.push_back(e);
  endtask

  task automatic expectWrap(input logic [7:0] ePc, input logic [15:0] eInstr, input logic [15:0] eRet);
    exp_t e;
    e.pc = ePc; e.instr = eInstr; e.retired = eRet; e.flags = 3'b000;
    wrapQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ePc, input logic [1:0] eState,
                             input logic [15:0] eRet, input logic [2:0] eFlags, input logic eValid,
                             input logic chkInstr, input logic [15:0] eInstr);
    @(negedge clk);
    total++;
    if (pc !== ePc || state !== eState || retired !== eRet || flags !== eFlags ||
        instrValid !== eValid || (chkInstr && instr !== eInstr)) begin
      bad++;
      $display("[TB] FAIL %s got pc=%h st=%0d ret=%0d flags=%b valid=%b instr=%h want pc=%h st=%0d ret=%0d flags=%b valid=%b instr=%h",
               name, pc, state, retired, flags, instrValid, instr, ePc, eState, eRet, eFlags, eValid, eInstr);
    end
  endtask

  initial begin
    clearInputs();
    rst  = 1;
    wRst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    checkOutput("resetState", 8'h00, 2'd0, 16'd0, 3'b000, 1'b0, 1'b0, 16'h0000);

    // Program load in IDLE
    for (int a = 0; a < 16; a++) begin
      applyStimulus(); loadEn = 1; loadAddr = 8'(a); loadData = 16'(a + 1);
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(); loadEn = 1; loadAddr = 8'(8'h40 + k); loadData = 16'(16'h4000 + k);
    end
    applyStimulus(); start = 1;
    checkOutput("idleBeforeStart", 8'h00, 2'd0, 16'd0, 3'b000, 1'b0, 1'b1, 16'h0001);

    // Sequential fetch, RUN-time load ignored
    applyStimulus(); expectFetch(8'h00, 16'h0001, 16'd0, 3'b000);
    applyStimulus(); loadEn = 1; loadAddr = 8'h05; loadData = 16'hBEEF;
    expectFetch(8'h01, 16'h0002, 16'd1, 3'b000);
    applyStimulus(); expectFetch(8'h02, 16'h0003, 16'd2, 3'b000);
    applyStimulus(); expectFetch(8'h03, 16'h0004, 16'd3, 3'b000);

    // Conditional branches
    applyStimulus(); flagsWrite = 1; zIn = 1;
    expectFetch(8'h04, 16'h0005, 16'd4, 3'b000);
    applyStimulus(); isJz = 1; jumpTarget = 8'h40;
    expectFetch(8'h05, 16'h0006, 16'd5, 3'b100);
    applyStimulus(); flagsWrite = 1; lIn = 1;
    expectFetch(8'h40, 16'h4000, 16'd6, 3'b100);
    applyStimulus(); isJz = 1; jumpTarget = 8'h10;
    expectFetch(8'h41, 16'h4001, 16'd7, 3'b010);
    applyStimulus(); flagsWrite = 1; zIn = 1; isJz = 1; jumpTarget = 8'h10;
    expectFetch(8'h42, 16'h4002, 16'd8, 3'b010);
    applyStimulus(); isJnz = 1; isJl = 1; jumpTarget = 8'h01;
    expectFetch(8'h43, 16'h4003, 16'd9, 3'b100);
    applyStimulus(); flagsWrite = 1; gIn = 1; isJz = 1; jumpTarget = 8'h08;
    expectFetch(8'h44, 16'h4004, 16'd10, 3'b100);
    applyStimulus(); isJg = 1; isJl = 1; jumpTarget = 8'h45;
    expectFetch(8'h08, 16'h0009, 16'd11, 3'b001);

    // Stall holds everything, even with a flag write and jump pending
    for (int s = 0; s < 3; s++) begin
      applyStimulus(); stall = 1; flagsWrite = 1; zIn = 1; isJump = 1; jumpTarget = 8'h00;
      checkOutput("stallHold", 8'h45, 2'd1, 16'd12, 3'b001, 1'b0, 1'b1, 16'h4005);
    end

    // Halt wins over stall and jump
    applyStimulus(); haltReq = 1; stall = 1; isJump = 1; jumpTarget = 8'h00;
    checkOutput("haltPriority", 8'h45, 2'd1, 16'd12, 3'b001, 1'b0, 1'b1, 16'h4005);
    applyStimulus(); haltReq = 1; loadEn = 1; loadAddr = 8'h05; loadData = 16'hCAFE;
    checkOutput("halted", 8'h45, 2'd2, 16'd12, 3'b001, 1'b0, 1'b1, 16'h4005);
    applyStimulus(); start = 1;
    checkOutput("haltStillHalted", 8'h45, 2'd2, 16'd12, 3'b001, 1'b0, 1'b1, 16'h4005);

    // Resume at the same pc, then reach the word loaded during HALT
    applyStimulus(); isJump = 1; jumpTarget = 8'h04;
    expectFetch(8'h45, 16'h4005, 16'd12, 3'b001);
    applyStimulus(); expectFetch(8'h04, 16'h0005, 16'd13, 3'b001);
    applyStimulus(); start = 1;
    expectFetch(8'h05, 16'hCAFE, 16'd14, 3'b001);

    // Reset during a taken jump, then reset during a load
    applyStimulus(); rst = 1; isJump = 1; jumpTarget = 8'h40;
    expectFetch(8'h06, 16'h0007, 16'd15, 3'b001);
    applyStimulus(); rst = 1; loadEn = 1; loadAddr = 8'h00; loadData = 16'hFFFF;
    checkOutput("resetMidJump", 8'h00, 2'd0, 16'd0, 3'b000, 1'b0, 1'b1, 16'h0001);
    applyStimulus(); rst = 0; start = 1;
    checkOutput("resetDropsLoad", 8'h00, 2'd0, 16'd0, 3'b000, 1'b0, 1'b1, 16'h0001);
    applyStimulus(); expectFetch(8'h00, 16'h0001, 16'd0, 3'b000);
    applyStimulus(); haltReq = 1;
    expectFetch(8'h01, 16'h0002, 16'd1, 3'b000);
    applyStimulus();
    checkOutput("finalHalt", 8'h01, 2'd2, 16'd1, 3'b000, 1'b0, 1'b1, 16'h0002);

    // Wrap-around instance: RESET_PC=FE, 2-bit saturating retire counter
    applyStimulus(); wRst = 0; wLoadEn = 1; wLoadAddr = 8'hFE; wLoadData = 16'hF0FE;
    applyStimulus(); wLoadEn = 1; wLoadAddr = 8'hFF; wLoadData = 16'hF0FF;
    applyStimulus(); wLoadEn = 1; wLoadAddr = 8'h00; wLoadData = 16'hF000;
    applyStimulus(); wLoadEn = 1; wLoadAddr = 8'h01; wLoadData = 16'hF001;
    applyStimulus(); wLoadEn = 1; wLoadAddr = 8'h02; wLoadData = 16'hF002;
    applyStimulus(); wStart = 1;
    applyStimulus(); expectWrap(8'hFE, 16'hF0FE, 16'd0);
    applyStimulus(); expectWrap(8'hFF, 16'hF0FF, 16'd1);
    applyStimulus(); expectWrap(8'h00, 16'hF000, 16'd2);
    applyStimulus(); expectWrap(8'h01, 16'hF001, 16'd3);
    applyStimulus(); wRst = 1; expectWrap(8'h02, 16'hF002, 16'd3);

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && (expQ.size() != 0 || wrapQ.size() != 0); w++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    total++;
    if (expQ.size() != 0 || wrapQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got pending main=%0d wrap=%0d want 0", expQ.size(), wrapQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
